// File: rtl/ft245_device_emulator.sv
// ft245_device_emulator
//   Device (FTDI-chip) side of an FT245 asynchronous FIFO bus. The host
//   strobes rd_n/wr_n against the rxf_n/txe_n flags. Bytes are buffered in
//   two FIFOs and exchanged with the fabric through valid/ready handshakes.
//
//   Ports
//     clk, rst            system clock, asynchronous active-low reset
//     data_in             host-driven pad byte during writes
//     data_out, data_oe   pad byte and its output enable for host reads
//     rxf_n, rd_n         read-available flag / host read strobe
//     txe_n, wr_n         write-room flag / host write strobe
//     h2d_data/valid/ready  host-to-device byte stream toward the fabric
//     d2h_data/valid/ready  device-to-host byte stream from the fabric
//     protocol_err        sticky: [0] read while rxf_n high,
//                                 [1] write while txe_n high
//
//   Build option
//     FT245_EMU_LOOPBACK_EN : bytes written by the host go into the d2h FIFO.
//                             The fabric ports are ignored, h2d_valid and
//                             d2h_ready are held low.
module ft245_device_emulator #(
  parameter int unsigned DEPTH_LOG2          = 4,
  parameter int unsigned RXF_INACTIVE_CYCLES = 8,
  parameter int unsigned TXE_INACTIVE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       rxf_n,
  input  logic       rd_n,
  output logic       txe_n,
  input  logic       wr_n,
  output logic [7:0] h2d_data,
  output logic       h2d_valid,
  input  logic       h2d_ready,
  input  logic [7:0] d2h_data,
  input  logic       d2h_valid,
  output logic       d2h_ready,
  output logic [1:0] protocol_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned RD_CW = $clog2(RXF_INACTIVE_CYCLES + 2);
  localparam int unsigned WR_CW = $clog2(TXE_INACTIVE_CYCLES + 2);
  // A zero cycle count still spends one cycle in precharge.
  localparam logic [RD_CW-1:0] RD_TERM =
    RD_CW'((RXF_INACTIVE_CYCLES == 0) ? 0 : RXF_INACTIVE_CYCLES - 1);
  localparam logic [WR_CW-1:0] WR_TERM =
    WR_CW'((TXE_INACTIVE_CYCLES == 0) ? 0 : TXE_INACTIVE_CYCLES - 1);

  typedef enum logic [1:0] {RD_IDLE, RD_DRIVE, RD_PRECHARGE} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_PRECHARGE} wr_state_t;

  function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    return (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  endfunction

  // ---------------------------------------------------------------- sync
  logic [1:0] rd_sync, wr_sync;
  logic       rd_prev, wr_prev;
  logic [7:0] din_s1, din_s2;
  logic       rd_fall, rd_rise, wr_fall, wr_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sync <= '1;
      wr_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
      din_s1  <= '0;
      din_s2  <= '0;
    end else begin
      rd_sync <= {rd_sync[0], rd_n};
      wr_sync <= {wr_sync[0], wr_n};
      rd_prev <= rd_sync[1];
      wr_prev <= wr_sync[1];
      din_s1  <= data_in;
      din_s2  <= din_s1;
    end
  end

  assign rd_fall =  rd_prev & ~rd_sync[1];
  assign rd_rise = ~rd_prev &  rd_sync[1];
  assign wr_fall =  wr_prev & ~wr_sync[1];
  assign wr_rise = ~wr_prev &  wr_sync[1];

  // --------------------------------------------------------------- FIFOs
  logic [7:0]    d2h_mem [DEPTH];
  logic [7:0]    h2d_mem [DEPTH];
  logic [PW-1:0] d2h_wp, d2h_rp, h2d_wp, h2d_rp;
  logic [PW-1:0] d2h_wp_nxt, d2h_rp_nxt, h2d_wp_nxt, h2d_rp_nxt;
  logic          d2h_push, d2h_pop, h2d_push, h2d_pop;
  logic [7:0]    d2h_wdata;
  logic          d2h_empty, h2d_empty;
  logic          d2h_empty_nxt, d2h_full_nxt, h2d_full_nxt;
  logic          wr_capture;
  logic          d2h_ready_nxt, txe_room_nxt;

  assign d2h_empty = (d2h_wp == d2h_rp);
  assign h2d_empty = (h2d_wp == h2d_rp);

`ifdef FT245_EMU_LOOPBACK_EN
  logic unused_fabric;
  assign unused_fabric = ^{h2d_ready, d2h_data, d2h_valid};
  assign d2h_push      = wr_capture;
  assign d2h_wdata     = din_s2;
  assign h2d_push      = 1'b0;
  assign h2d_pop       = 1'b0;
  assign h2d_valid     = 1'b0;
  assign d2h_ready_nxt = 1'b0;
  // Loopback bytes land in d2h, so host writes also need room there.
  assign txe_room_nxt  = !h2d_full_nxt && !d2h_full_nxt;
`else
  assign d2h_push      = d2h_valid && d2h_ready;
  assign d2h_wdata     = d2h_data;
  assign h2d_push      = wr_capture;
  assign h2d_pop       = h2d_valid && h2d_ready;
  assign h2d_valid     = !h2d_empty;
  assign d2h_ready_nxt = !d2h_full_nxt;
  assign txe_room_nxt  = !h2d_full_nxt;
`endif

  assign d2h_wp_nxt    = d2h_wp + PW'(d2h_push);
  assign d2h_rp_nxt    = d2h_rp + PW'(d2h_pop);
  assign h2d_wp_nxt    = h2d_wp + PW'(h2d_push);
  assign h2d_rp_nxt    = h2d_rp + PW'(h2d_pop);
  assign d2h_empty_nxt = (d2h_wp_nxt == d2h_rp_nxt);
  assign d2h_full_nxt  = ptr_full(d2h_wp_nxt, d2h_rp_nxt);
  assign h2d_full_nxt  = ptr_full(h2d_wp_nxt, h2d_rp_nxt);
  assign h2d_data      = h2d_mem[h2d_rp[PW-2:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d2h_wp <= '0;
      d2h_rp <= '0;
      h2d_wp <= '0;
      h2d_rp <= '0;
    end else begin
      d2h_wp <= d2h_wp_nxt;
      d2h_rp <= d2h_rp_nxt;
      h2d_wp <= h2d_wp_nxt;
      h2d_rp <= h2d_rp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (d2h_push) d2h_mem[d2h_wp[PW-2:0]] <= d2h_wdata;
  end

  always_ff @(posedge clk) begin
    if (h2d_push) h2d_mem[h2d_wp[PW-2:0]] <= din_s2;
  end

  // ------------------------------------------------------------ read FSM
  rd_state_t        rd_state, rd_next;
  logic [RD_CW-1:0] rd_cnt;
  logic             rd_start, rd_err;

  always_comb begin
    rd_next  = rd_state;
    rd_start = 1'b0;
    d2h_pop  = 1'b0;
    rd_err   = rd_fall && rxf_n;
    case (rd_state)
      RD_IDLE:      if (rd_fall && !rxf_n) begin
                      rd_next  = RD_DRIVE;
                      rd_start = 1'b1;
                    end
      RD_DRIVE:     if (rd_rise) begin
                      rd_next = RD_PRECHARGE;
                      d2h_pop = 1'b1;
                    end
      RD_PRECHARGE: if (rd_cnt == RD_TERM) rd_next = RD_IDLE;
      default:      rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state != RD_PRECHARGE) rd_cnt <= '0;
      else if (rd_cnt != RD_TERM)   rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // ----------------------------------------------------------- write FSM
  wr_state_t        wr_state, wr_next;
  logic [WR_CW-1:0] wr_cnt;
  logic             wr_err;

  always_comb begin
    wr_next    = wr_state;
    wr_capture = 1'b0;
    wr_err     = wr_fall && txe_n;
    case (wr_state)
      WR_IDLE:      if (wr_fall && !txe_n) begin
                      wr_next    = WR_ACTIVE;
                      wr_capture = 1'b1;
                    end
      WR_ACTIVE:    if (wr_rise) wr_next = WR_PRECHARGE;
      WR_PRECHARGE: if (wr_cnt == WR_TERM) wr_next = WR_IDLE;
      default:      wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= WR_IDLE;
      wr_cnt   <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_state != WR_PRECHARGE) wr_cnt <= '0;
      else if (wr_cnt != WR_TERM)   wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------- registered flags
  // Flags are computed from next-state values so that a low rxf_n/txe_n
  // always implies the matching FSM is idle with data/room available.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxf_n        <= 1'b1;
      txe_n        <= 1'b1;
      data_oe      <= 1'b0;
      data_out     <= '0;
      d2h_ready    <= 1'b0;
      protocol_err <= '0;
    end else begin
      rxf_n        <= !((rd_next == RD_IDLE) && !d2h_empty_nxt);
      txe_n        <= !((wr_next == WR_IDLE) && txe_room_nxt);
      data_oe      <= (rd_next == RD_DRIVE);
      d2h_ready    <= d2h_ready_nxt;
      protocol_err <= protocol_err | {wr_err, rd_err};
      if (rd_start && !d2h_empty) data_out <= d2h_mem[d2h_rp[PW-2:0]];
    end
  end

endmodule
